// File: rtl/gate_bist_checker.sv
// gate_bist_checker: drives the four (a,b) vectors to a basic-gate block and checks its seven outputs.
module gate_bist_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  input  logic             h,
  input  logic             i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_mask,
  output logic [1:0]       first_fail
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ERR_W+2:0] MAX = {3'b000, {ERR_W{1'b1}}};
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [6:0] obs, exp_v, mism;
  logic [2:0] pop;
  logic [ERR_W+2:0] sum;
  assign obs = {c, d, e, f, g, h, i};
  assign busy = state != IDLE;
  always_comb begin
    exp_v = {a & b, ~(a & b), a | b, ~(a | b), ~a, a ^ b, ~(a ^ b)};
    mism = '0;
    pop = '0;
    // unknown observed bits are treated as mismatches
    for (int k = 0; k < 7; k++) begin
      mism[k] = obs[k] !== exp_v[k];
      pop = pop + 3'(mism[k]);
    end
    sum = (ERR_W+3)'(err_count) + (ERR_W+3)'(pop);
    state_n = state == IDLE   ? (start ? SETTLE : IDLE) :
              state == SETTLE ? (cnt == '0 ? SAMPLE : SETTLE) :
              state == SAMPLE ? ({a, b} == 2'b11 ? DONE : SETTLE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {a, b} <= 2'b00;
      cnt <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      fail_mask <= '0;
      first_fail <= '0;
    end else begin
      state <= state_n;
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          {a, b} <= 2'b00;
          cnt <= CW'(SETTLE_CYCLES - 1);
          pass <= 1'b0;
          err_count <= '0;
          fail_mask <= '0;
          first_fail <= '0;
        end
        SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
        SAMPLE: begin
          err_count <= sum > MAX ? MAX[ERR_W-1:0] : sum[ERR_W-1:0];
          fail_mask <= fail_mask | mism;
          if (fail_mask == '0 && |mism) first_fail <= {a, b};
          if ({a, b} != 2'b11) begin
            {a, b} <= {a, b} + 2'd1;
            cnt <= CW'(SETTLE_CYCLES - 1);
          end
        end
        DONE: pass <= err_count == '0 && fail_mask == '0;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_bist_checker.sv
// tb_gate_bist_checker: directed table of faulty gate models plus multi-cycle corner sequences.
module tb_gate_bist_checker;
  logic clk = 0, rst = 1, start = 0;
  int mode = 0;
  int nvec = 0, nerr = 0;
  logic a, b, busy, done, pass;
  logic [4:0] err_count;
  logic [6:0] fail_mask, obs;
  logic [1:0] first_fail;
  logic a2, b2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [6:0] mask2, obs2;
  logic [1:0] first2;

  always #5 clk = ~clk;

  // gate block model with injectable faults; bits {c,d,e,f,g,h,i} = 6..0
  function automatic logic [6:0] model(input logic aa, input logic bb, input int m);
    logic [6:0] r;
    r = {aa & bb, ~(aa & bb), aa | bb, ~(aa | bb), ~aa, aa ^ bb, ~(aa ^ bb)};
    if (m == 1) r[1] = 1'b0;
    if (m == 2) r = ~r;
    if (m == 3) r[6] = 1'b1;
    if (m == 4) r[2] = 1'b0;
    if (m == 5 && aa && bb) r[3] = ~r[3];
    if (m == 6) r[2] = ~bb;
    return r;
  endfunction

  assign obs = model(a, b, mode);
  assign obs2 = model(a2, b2, 2);

  gate_bist_checker dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .c(obs[6]), .d(obs[5]), .e(obs[4]), .f(obs[3]), .g(obs[2]), .h(obs[1]), .i(obs[0]),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_mask(fail_mask), .first_fail(first_fail)
  );

  gate_bist_checker #(.SETTLE_CYCLES(2), .ERR_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .a(a2), .b(b2),
    .c(obs2[6]), .d(obs2[5]), .e(obs2[4]), .f(obs2[3]), .g(obs2[2]), .h(obs2[1]), .i(obs2[0]),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_mask(mask2), .first_fail(first2)
  );

  typedef struct {
    int mode;
    int pass;
    int err;
    int mask;
    int first;
  } vec_t;
  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sweep(input int pulse_at, output int lat, output logic [7:0] seq);
    start = 1;
    tick();
    start = 0;
    lat = -1;
    seq = '0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) check("busy_after_accept", int'(busy), 1);
      if (n == pulse_at) start = 1;
      if (n == pulse_at + 1) start = 0;
      if (n == 1 || n == 4 || n == 7 || n == 10) seq = {seq[5:0], a, b};
      if (done) begin
        lat = n;
        break;
      end
    end
    check("done_latency", lat, 13);
  endtask

  initial begin
    int lat, k;
    logic [7:0] seq;
    int exp6[3] = '{13, 27, 41};
    tbl[0] = '{0, 1, 0, 7'h00, 0};
    tbl[1] = '{1, 0, 2, 7'b0000010, 1};
    tbl[2] = '{2, 0, 28, 7'h7F, 0};
    tbl[3] = '{3, 0, 3, 7'b1000000, 0};
    tbl[4] = '{4, 0, 2, 7'b0000100, 0};
    tbl[5] = '{5, 0, 1, 7'b0001000, 3};
    tbl[6] = '{6, 0, 2, 7'b0000100, 1};

    repeat (3) tick();
    rst = 0;
    check("rst_ab", int'({a, b}), 0);
    check("rst_busy_done_pass", int'({busy, done, pass}), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_mask", int'(fail_mask), 0);
    check("rst_first", int'(first_fail), 0);

    foreach (tbl[j]) begin
      mode = tbl[j].mode;
      tick();
      sweep(-10, lat, seq);
      check($sformatf("v%0d_pass", j), int'(pass), tbl[j].pass);
      check($sformatf("v%0d_err", j), int'(err_count), tbl[j].err);
      check($sformatf("v%0d_mask", j), int'(fail_mask), tbl[j].mask);
      check($sformatf("v%0d_first", j), int'(first_fail), tbl[j].first);
      if (j == 0) begin
        check("seq_ab", int'(seq), 8'h1B);
        check("sat_done", int'(done2), 1);
        check("sat_err", int'(err2), 7);
        check("sat_mask", int'(mask2), 7'h7F);
        check("sat_first", int'(first2), 0);
        check("sat_pass", int'(pass2), 0);
      end
      tick();
      check($sformatf("v%0d_done_pulse", j), int'(done), 0);
    end

    repeat (5) tick();
    check("hold_err", int'(err_count), 2);
    check("hold_mask", int'(fail_mask), 7'b0000100);
    check("hold_first", int'(first_fail), 1);

    // restart pulse during SETTLE of vector 2 must be ignored
    mode = 0;
    sweep(6, lat, seq);
    check("t4_seq_ab", int'(seq), 8'h1B);
    check("t4_pass", int'(pass), 1);
    k = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done) k++;
    end
    check("t4_extra_done", k, 0);
    check("t4_idle", int'(busy), 0);

    // reset during SAMPLE of vector 1
    mode = 1;
    start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    check("t5_busy", int'(busy), 0);
    check("t5_ab", int'({a, b}), 0);
    check("t5_done", int'(done), 0);
    check("t5_err", int'(err_count), 0);
    k = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (done) k++;
    end
    check("t5_no_done", k, 0);
    mode = 0;
    sweep(-10, lat, seq);
    check("t5_clean_pass", int'(pass), 1);
    check("t5_clean_err", int'(err_count), 0);
    repeat (2) tick();

    // start held high: back-to-back sweeps
    start = 1;
    tick();
    k = 0;
    for (int n = 1; n <= 45; n++) begin
      tick();
      if (n == 40) start = 0;
      if (done) begin
        check("t6_done_at", n, k < 3 ? exp6[k] : -1);
        check("t6_pass", int'(pass), 1);
        k++;
      end
    end
    check("t6_done_count", k, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
